sm4_key_expand: RTL and testbench
=================================

Name: sm4_key_expand

Overview:
Iterative SM4 key schedule (GB/T 32907) that expands a 128-bit master key into the 32 round keys rk0..rk31, one per clock. It sits directly upstream of the combinational SM4 round datapath (x4 = x0 ^ T(x1^x2^x3^rk)) and supplies its rk input. Keys are streamed out as they are produced and also held in an internal 32x32 buffer, which the round controller reads by index.

Parameters:
ROUNDS, 32, number of round keys generated; only 32 is supported.
IDX_W, 5, width of the round index and read address; must equal clog2(ROUNDS).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to expand mk; accepted only when busy=0
mk  input  128  master key MK0..MK3, MK0 = mk[127:96]; sampled on the accepted start
busy  output  1  high while expansion runs
rk_out  output  32  most recently generated round key (registered)
rk_valid  output  1  one-cycle pulse per generated key
rk_idx  output  IDX_W  index of the key in rk_out
key_ready  output  1  level: all 32 keys are valid in the buffer
rd_addr  input  IDX_W  buffer read index
rd_dec  input  1  decrypt-order read select (used only with SM4_KEY_DEC_EN)
rk_rdata  output  32  combinational buffer read data

Behaviour:
- Clocking: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, cnt=0, K0..K3=0, busy=0, rk_out=0, rk_valid=0, rk_idx=0, key_ready=0. All 32 buffer entries are cleared to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start: go to RUN. Load K0..K3 = MKi ^ FKi, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC. Set cnt=0, busy=1, key_ready=0.
  - RUN: each cycle compute k = K0 ^ T'(K1^K2^K3^CK[cnt]) and shift {K0,K1,K2,K3} <= {K1,K2,K3,k}. Register rk_out=k, rk_idx=cnt, rk_valid=1, and write buf[cnt]=k. When cnt==31, go to DONE, drop busy, and set key_ready=1 on that same edge. Otherwise increment cnt.
  - DONE: hold the buffer and key_ready. rk_valid=0.
- start while busy=1 is ignored, with no effect on the run in progress.
- Latency: start accepted at edge 0. rk0 is visible after edge 1; rk31 and key_ready are visible after edge 32. busy is high for exactly 32 cycles.
- Round transform:
  - T'(B) = L'(tau(B)), where tau applies the SM4 S-box to each byte.
  - L'(B) = B ^ rotl(B,13) ^ rotl(B,23). Rotations are 32-bit circular.
- CK generation: computed from cnt, no table. Byte j of CK[i] (j=0 is the MSB byte) is (28*i + 7*j) mod 256.
  - Example: CK[0]=00070E15, CK[31]=646B7279.
- Read port:
  - rk_rdata = buf[rd_addr], combinational.
  - Contents are defined only while key_ready=1. While RUN, the read returns a mix of old and new entries and must not be checked.
- Re-key from DONE: key_ready drops on the accepting edge. Entries are overwritten in index order.
- Reset mid-RUN: returns immediately to the reset values above, including a cleared buffer. No rk_valid is produced after rst_n falls.

Optional Feature:
SM4_KEY_DEC_EN:
- Defined: when rd_dec=1, rk_rdata = buf[31 - rd_addr], so the round controller can decrypt by stepping rd_addr 0..31. When rd_dec=0, behaviour is as normal.
- Undefined: rd_dec is ignored (port kept, unused), and rk_rdata = buf[rd_addr] always.

Test Plan:
- Reset: assert rst_n=0 mid-sim -> all outputs 0 and busy=0. Every rd_addr 0..31 reads 00000000.
- Standard vector: mk=0123456789ABCDEFFEDCBA9876543210, start pulse ->
  - rk_valid on 32 consecutive cycles with rk_idx 0..31.
  - rk0=F12186F9, rk1=41662B61, rk2=5A6AB19A, rk31=9124A012.
  - key_ready high at the cycle rk31 appears. busy low the next cycle.
- Buffer read after key_ready: rd_addr=0 -> F12186F9, rd_addr=31 -> 9124A012.
  - With SM4_KEY_DEC_EN and rd_dec=1: rd_addr=0 -> 9124A012.
- start at cycles 5 and 20 of a run with different mk -> ignored. The output sequence still matches the standard vector, and exactly 32 rk_valid pulses occur.
- Re-key: from DONE, start with mk=0 -> key_ready falls next cycle. 32 new keys follow, and rk31 matches the golden model.
- rst_n low at cycle 10 of a run -> rk_valid stops immediately and key_ready stays 0. A fresh start then regenerates rk0=F12186F9.

Source files
------------

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: expands a 128-bit master key into 32 round keys, one per clock,
// streams each key out and keeps it in a 32x32 buffer. Optional macro SM4_KEY_DEC_EN adds reversed-order reads.
module sm4_key_expand #(
  parameter int ROUNDS = 32,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     mk,
  output logic             busy,
  output logic [31:0]      rk_out,
  output logic             rk_valid,
  output logic [IDX_W-1:0] rk_idx,
  output logic             key_ready,
  input  logic [IDX_W-1:0] rd_addr,
  input  logic             rd_dec,
  output logic [31:0]      rk_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  // Key-schedule round function: byte-wise S-box followed by the key-side linear mix L'.
  function automatic logic [31:0] t_prime(input logic [31:0] b);
    logic [31:0] s;
    s = {SBOX[b[31:24]], SBOX[b[23:16]], SBOX[b[15:8]], SBOX[b[7:0]]};
    return s ^ {s[18:0], s[31:19]} ^ {s[8:0], s[31:9]};
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       k_q, k_d;
  logic               busy_q, busy_d;
  logic [31:0]        rk_out_q, rk_out_d;
  logic               rk_valid_q, rk_valid_d;
  logic [IDX_W-1:0]   rk_idx_q, rk_idx_d;
  logic               key_ready_q, key_ready_d;
  logic [31:0]        key_buf_q [ROUNDS];
  logic [31:0]        key_buf_d [ROUNDS];
  logic [7:0]         ck_base;
  logic [31:0]        ck;
  logic [31:0]        k_new;
  logic [IDX_W-1:0]   rd_idx;

  // CK bytes step by 7 within a word and by 28 between rounds, all mod 256.
  assign ck_base = 8'(cnt_q) * 8'd28;
  assign ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
  assign k_new   = k_q[127:96] ^ t_prime(k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    busy_d      = busy_q;
    rk_out_d    = rk_out_q;
    rk_valid_d  = 1'b0;
    rk_idx_d    = rk_idx_q;
    key_ready_d = key_ready_q;
    key_buf_d   = key_buf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          k_d         = mk ^ FK;
          cnt_d       = '0;
          busy_d      = 1'b1;
          key_ready_d = 1'b0;
        end
      end
      RUN: begin
        k_d              = {k_q[95:0], k_new};
        rk_out_d         = k_new;
        rk_idx_d         = cnt_q;
        rk_valid_d       = 1'b1;
        key_buf_d[cnt_q] = k_new;
        if (cnt_q == IDX_W'(ROUNDS - 1)) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          key_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      rk_out_q    <= '0;
      rk_valid_q  <= 1'b0;
      rk_idx_q    <= '0;
      key_ready_q <= 1'b0;
      for (int i = 0; i < ROUNDS; i++) key_buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      rk_out_q    <= rk_out_d;
      rk_valid_q  <= rk_valid_d;
      rk_idx_q    <= rk_idx_d;
      key_ready_q <= key_ready_d;
      key_buf_q   <= key_buf_d;
    end
  end

`ifdef SM4_KEY_DEC_EN
  // Reversed addressing lets the round controller walk 0..31 for decryption.
  assign rd_idx = rd_dec ? (IDX_W'(ROUNDS - 1) - rd_addr) : rd_addr;
`else
  logic unused_rd_dec;
  assign unused_rd_dec = rd_dec;
  assign rd_idx        = rd_addr;
`endif

  assign rk_rdata  = key_buf_q[rd_idx];
  assign busy      = busy_q;
  assign rk_out    = rk_out_q;
  assign rk_valid  = rk_valid_q;
  assign rk_idx    = rk_idx_q;
  assign key_ready = key_ready_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench for sm4_key_expand: golden-vector table, ignored starts, re-key from DONE and mid-run reset.
module tb_sm4_key_expand;

  localparam logic [127:0] STD_MK = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  localparam logic [7:0] SB [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] exp;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] mk;
  logic         busy;
  logic [31:0]  rk_out;
  logic         rk_valid;
  logic [4:0]   rk_idx;
  logic         key_ready;
  logic [4:0]   rd_addr;
  logic         rd_dec;
  logic [31:0]  rk_rdata;

  int          checks;
  int          failures;
  int          pulses;
  int          order_errs;
  int          busy_cnt;
  int          first_c;
  int          last_c;
  logic        ready_at0;
  logic        ready_last;
  logic        busy_after_last;
  logic [31:0] cap [32];
  vec_t        vecs [4];

  sm4_key_expand #(.ROUNDS(32), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mk(mk), .busy(busy),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_idx(rk_idx), .key_ready(key_ready),
    .rd_addr(rd_addr), .rd_dec(rd_dec), .rk_rdata(rk_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] model_rk(input logic [127:0] key, input int n);
    logic [31:0] fks [4];
    logic [31:0] kk [36];
    logic [31:0] ckv;
    logic [31:0] x;
    logic [31:0] s;
    fks[0] = 32'hA3B1BAC6; fks[1] = 32'h56AA3350; fks[2] = 32'h677D9197; fks[3] = 32'hB27022DC;
    for (int i = 0; i < 4; i++) kk[i] = key[127 - 32*i -: 32] ^ fks[i];
    for (int i = 0; i <= n; i++) begin
      for (int j = 0; j < 4; j++) ckv[31 - 8*j -: 8] = 8'((28*i + 7*j) % 256);
      x = kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ckv;
      for (int j = 0; j < 4; j++) s[8*j +: 8] = SB[x[8*j +: 8]];
      kk[i+4] = kk[i] ^ s ^ rotl(s, 13) ^ rotl(s, 23);
    end
    return kk[n+4];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Pulses start with the given key, then samples every negedge for ncyc cycles.
  task automatic applyStimulus(input logic [127:0] key, input bit inject, input int ncyc);
    pulses = 0; order_errs = 0; busy_cnt = 0; first_c = -1; last_c = -1;
    ready_last = 1'b0; busy_after_last = 1'b1;
    for (int i = 0; i < 32; i++) cap[i] = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b1; mk = key;
    @(negedge clk);
    start = 1'b0;
    ready_at0 = key_ready;
    if (busy) busy_cnt++;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (rk_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (pulses >= 32 || rk_idx != 5'(pulses)) order_errs++;
        else cap[rk_idx] = rk_out;
        if (rk_idx == 5'd31) ready_last = key_ready;
        pulses++;
      end
      if (c == 33) busy_after_last = busy;
      start = inject && (c == 5 || c == 20);
      if (start) mk = ~key;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    checkOutput({tag, " pulses"}, 32'(pulses), 32'd32);
    checkOutput({tag, " idx order errors"}, 32'(order_errs), 32'd0);
    checkOutput({tag, " first pulse cycle"}, 32'(first_c), 32'd1);
    checkOutput({tag, " last pulse cycle"}, 32'(last_c), 32'd32);
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'd32);
    checkOutput({tag, " key_ready with rk31"}, 32'(ready_last), 32'd1);
    checkOutput({tag, " busy after rk31"}, 32'(busy_after_last), 32'd0);
  endtask

  task automatic check_buffer_zero(input string tag);
    int nz;
    nz = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1;
      if (rk_rdata !== 32'h0) nz++;
    end
    checkOutput({tag, " nonzero buffer entries"}, 32'(nz), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    vecs[0] = '{idx: 5'd0,  exp: 32'hF12186F9};
    vecs[1] = '{idx: 5'd1,  exp: 32'h41662B61};
    vecs[2] = '{idx: 5'd2,  exp: 32'h5A6AB19A};
    vecs[3] = '{idx: 5'd31, exp: 32'h9124A012};

    rst_n = 1'b0; start = 1'b0; mk = '0; rd_addr = '0; rd_dec = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rk_valid", 32'(rk_valid), 32'd0);
    checkOutput("reset rk_out", rk_out, 32'h0);
    checkOutput("reset rk_idx", 32'(rk_idx), 32'd0);
    checkOutput("reset key_ready", 32'(key_ready), 32'd0);
    check_buffer_zero("reset");

    $display("[TB] standard vector");
    applyStimulus(STD_MK, 1'b0, 36);
    check_run("std");
    for (int v = 0; v < 4; v++) begin
      checkOutput($sformatf("std stream rk%0d", vecs[v].idx), cap[vecs[v].idx], vecs[v].exp);
      rd_addr = vecs[v].idx;
      #1;
      checkOutput($sformatf("std buffer rk%0d", vecs[v].idx), rk_rdata, vecs[v].exp);
    end
`ifdef SM4_KEY_DEC_EN
    rd_dec = 1'b1; rd_addr = 5'd0;
    #1 checkOutput("dec read addr0", rk_rdata, 32'h9124A012);
    rd_addr = 5'd31;
    #1 checkOutput("dec read addr31", rk_rdata, 32'hF12186F9);
    rd_dec = 1'b0;
`endif

    $display("[TB] starts during run are ignored");
    applyStimulus(STD_MK, 1'b1, 36);
    check_run("ignore");
    for (int v = 0; v < 4; v++)
      checkOutput($sformatf("ignore stream rk%0d", vecs[v].idx), cap[vecs[v].idx], vecs[v].exp);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("ignore model rk%0d", i), cap[i], model_rk(STD_MK, i));

    $display("[TB] re-key from DONE with mk=0");
    checkOutput("ready before re-key", 32'(key_ready), 32'd1);
    applyStimulus(128'h0, 1'b0, 36);
    checkOutput("re-key ready drops", 32'(ready_at0), 32'd0);
    check_run("rekey");
    checkOutput("rekey rk0", cap[0], model_rk(128'h0, 0));
    checkOutput("rekey rk31", cap[31], model_rk(128'h0, 31));
    rd_addr = 5'd31;
    #1 checkOutput("rekey buffer rk31", rk_rdata, model_rk(128'h0, 31));

    $display("[TB] reset in the middle of a run");
    @(negedge clk);
    start = 1'b1; mk = STD_MK;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midrun valid before reset", 32'(rk_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun rk_valid", 32'(rk_valid), 32'd0);
    checkOutput("midrun busy", 32'(busy), 32'd0);
    checkOutput("midrun key_ready", 32'(key_ready), 32'd0);
    checkOutput("midrun rk_out", rk_out, 32'h0);
    checkOutput("midrun rk_idx", 32'(rk_idx), 32'd0);
    begin
      int late;
      late = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (rk_valid || key_ready) late++;
      end
      checkOutput("midrun no pulses in reset", 32'(late), 32'd0);
    end
    check_buffer_zero("midrun");
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(STD_MK, 1'b0, 36);
    check_run("after reset");
    checkOutput("after reset rk0", cap[0], 32'hF12186F9);
    checkOutput("after reset rk31", cap[31], 32'h9124A012);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
